// File: rtl/keypad_pkg.sv
// Shared types, constants and the 4x4 key map for the matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CODE_W-1:0] KEY_CLEAR = 4'hE;
  localparam logic [CODE_W-1:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_res_e;

  // Row r, column c -> key code; '*' maps to E and '#' to F.
  function automatic logic [CODE_W-1:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [CODE_W-1:0] code;
    code = '0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_CLEAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_ENTER;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release qualification FSM; evaluated once per full keypad scan.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_end,
  input  logic [1:0]  res,
  input  logic [3:0]  code,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        accept_c,
  output logic [3:0]  accept_code_c
);

  kp_state_e        state_q, state_d;
  scan_res_e        res_e;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q, key_held_q;

  assign res_e = scan_res_e'(res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= accept_c;
      key_held_q  <= (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
      if (accept_c) key_code_q <= cand_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          if (res_e == SCAN_SINGLE) begin
            state_d = ST_DEBOUNCE;
            cand_d  = code;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if ((res_e == SCAN_SINGLE) && (code == cand_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d  = ST_PRESSED;
              accept_c = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          // No auto-repeat: only a clean NONE scan starts release qualification.
          if (res_e == SCAN_NONE) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (res_e == SCAN_NONE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) state_d = ST_IDLE;
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign key_held      = key_held_q;
  assign accept_code_c = cand_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row sync, column walk, scan classification,
// debounce and a two-digit entry register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 250,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [3:0]        row_s1, row_s2;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        idx_q;
  logic [3:0]        col_q;
  logic              sample_c, scan_end_c;
  logic [1:0]        hits_q, hits_c;
  logic [CODE_W-1:0] acc_code_q, code_c;
  scan_res_e         res_c;
  logic              accept_c;
  logic [3:0]        accept_code_c;
  logic [3:0]        digit_hi_q, digit_lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign sample_c   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign scan_end_c = sample_c && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      col_q <= 4'b1110;
    end else if (sample_c) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
      col_q <= {col_q[2:0], col_q[3]};
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Merge this column's sample into the running scan; hits saturates at 2 = MULTI.
  always_comb begin
    hits_c = hits_q;
    code_c = acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (hits_c != 2'd2) hits_c = hits_c + 2'd1;
        code_c = key_map(2'(r), idx_q);
      end
    end
    case (hits_c)
      2'd0:    res_c = SCAN_NONE;
      2'd1:    res_c = SCAN_SINGLE;
      default: res_c = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q     <= '0;
      acc_code_q <= '0;
    end else if (scan_end_c) begin
      hits_q     <= '0;
      acc_code_q <= '0;
    end else if (sample_c) begin
      hits_q     <= hits_c;
      acc_code_q <= code_c;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_end     (scan_end_c),
    .res          (res_c),
    .code         (code_c),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held),
    .accept_c     (accept_c),
    .accept_code_c(accept_code_c)
  );

  // Decimal keys shift in from the right; clear zeroes both; letters leave digits alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_hi_q <= '0;
      digit_lo_q <= '0;
    end else if (accept_c) begin
      if (accept_code_c <= 4'd9) begin
        digit_hi_q <= digit_lo_q;
        digit_lo_q <= accept_code_c;
      end else if (accept_code_c == KEY_CLEAR) begin
        digit_hi_q <= '0;
        digit_lo_q <= '0;
      end
    end
  end

  assign col      = col_q;
  assign digit_hi = digit_hi_q;
  assign digit_lo = digit_lo_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a pressed-key matrix model (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col, key_code, digit_hi, digit_lo;
  logic       key_valid, key_held;
  logic [3:0][3:0] keys;
  int n_pass   = 0;
  int n_checks = 0;
  int vcount   = 0;
  logic       v;
  logic [3:0] code;

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
  end

  always @(posedge clk) if (key_valid) vcount <= vcount + 1;

  keypad_scan #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digit_hi (digit_hi),
    .digit_lo (digit_lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns on the negedge just after a scan-end edge (col back to 1110).
  task automatic next_scan();
    int t = 0;
    while (col !== 4'b0111 && t < 64) begin @(negedge clk); t++; end
    while (col !== 4'b1110 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) begin
      n_checks++;
      $display("FAIL scan_timeout: col %b", col);
    end
  endtask

  task automatic scans(input int n);
    repeat (n) next_scan();
  endtask

  task automatic press_release(input int r, input int c, output logic vo, output logic [3:0] co);
    keys[r][c] = 1'b1;
    scans(3);
    vo = key_valid;
    co = key_code;
    keys[r][c] = 1'b0;
    scans(3);
  endtask

  initial begin
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_hi", digit_hi, 0);
    chk("rst_lo", digit_lo, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk); chk("walk_c1", col, 4'b1101);
    repeat (4) @(negedge clk); chk("walk_c2", col, 4'b1011);
    repeat (4) @(negedge clk); chk("walk_c3", col, 4'b0111);
    next_scan();

    // "5" held for 6 scans, then released
    keys[1][1] = 1'b1;
    scans(2);
    chk("k5_early", key_valid, 0);
    scans(1);
    chk("k5_valid", key_valid, 1);
    chk("k5_code", key_code, 5);
    chk("k5_lo", digit_lo, 5);
    chk("k5_hi", digit_hi, 0);
    chk("k5_held", key_held, 1);
    @(negedge clk);
    chk("k5_pulse", key_valid, 0);
    scans(3);
    chk("k5_held_long", key_held, 1);
    chk("k5_count", vcount, 1);
    keys[1][1] = 1'b0;
    scans(2);
    chk("k5_rel_held", key_held, 1);
    scans(1);
    chk("k5_rel_done", key_held, 0);
    chk("k5_norepeat", vcount, 1);

    // "8" bouncing for 4 scans, then stable
    for (int i = 0; i < 4; i++) begin
      keys[2][1] = (i % 2 == 0);
      scans(1);
    end
    keys[2][1] = 1'b1;
    scans(2);
    chk("k8_early", key_valid, 0);
    chk("k8_bounce_cnt", vcount, 1);
    scans(1);
    chk("k8_valid", key_valid, 1);
    chk("k8_code", key_code, 8);
    chk("k8_hi", digit_hi, 5);
    chk("k8_lo", digit_lo, 8);
    keys[2][1] = 1'b0;
    scans(3);
    chk("k8_rel", key_held, 0);

    // 2-scan "7" press is too short
    keys[2][0] = 1'b1;
    scans(2);
    keys[2][0] = 1'b0;
    scans(3);
    chk("short_cnt", vcount, 2);
    chk("short_code", key_code, 8);
    chk("short_held", key_held, 0);

    // Entry sequence 4, 2, then A (no digit change), then * (clear)
    press_release(1, 0, v, code);
    chk("k4_valid", v, 1);
    chk("k4_code", code, 4);
    press_release(0, 1, v, code);
    chk("k2_code", code, 2);
    chk("e42_hi", digit_hi, 4);
    chk("e42_lo", digit_lo, 2);
    press_release(0, 3, v, code);
    chk("kA_code", code, 4'hA);
    chk("kA_hi", digit_hi, 4);
    chk("kA_lo", digit_lo, 2);
    press_release(3, 0, v, code);
    chk("kE_code", code, 4'hE);
    chk("kE_hi", digit_hi, 0);
    chk("kE_lo", digit_lo, 0);
    chk("entry_cnt", vcount, 6);

    // "1" and "2" together, then release "1"
    keys[0][0] = 1'b1;
    keys[0][1] = 1'b1;
    scans(4);
    chk("multi_cnt", vcount, 6);
    chk("multi_held", key_held, 0);
    keys[0][0] = 1'b0;
    scans(2);
    chk("multi_early", key_valid, 0);
    scans(1);
    chk("multi_valid", key_valid, 1);
    chk("multi_code", key_code, 2);
    chk("multi_lo", digit_lo, 2);
    chk("multi_hi", digit_hi, 0);
    keys[0][1] = 1'b0;
    scans(3);

    // "9" re-pressed after a single release scan
    keys[2][2] = 1'b1;
    scans(3);
    chk("k9_valid", key_valid, 1);
    chk("k9_code", key_code, 9);
    chk("k9_hi", digit_hi, 2);
    chk("k9_lo", digit_lo, 9);
    keys[2][2] = 1'b0;
    scans(1);
    chk("k9_rel_held", key_held, 1);
    keys[2][2] = 1'b1;
    scans(3);
    chk("k9_repress_held", key_held, 1);
    chk("k9_repress_cnt", vcount, 8);

    // Reset mid-dwell on column 2 with "9" still down
    for (int t = 0; t < 32 && col !== 4'b1011; t++) @(negedge clk);
    chk("mid_col2", col, 4'b1011);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_hi", digit_hi, 0);
    chk("mid_rst_lo", digit_lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scans(2);
    chk("requal_early", key_valid, 0);
    scans(1);
    chk("requal_valid", key_valid, 1);
    chk("requal_code", key_code, 9);
    chk("requal_lo", digit_lo, 9);
    keys[2][2] = 1'b0;
    scans(3);
    chk("requal_rel", key_held, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
